// File: rtl/cry_level_eval.sv
// Crying-loudness window evaluator: averages fixed sample windows, compares
// successive averages and issues single-cycle step commands to the FAG counters.
module cry_level_eval #(
  parameter int LOG2_WIN = 4,
  parameter int HYST     = 8,
  parameter int QUIET    = 16,
  parameter int HOLDOFF  = 1000,
  parameter int F_MAX    = 15,
  parameter int F_MIN    = 1,
  parameter int A_MIN    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic [3:0] fag_f,
  input  logic [3:0] fag_a,
  output logic       f_hoog,
  output logic       f_laag,
  output logic       a_laag,
  output logic [7:0] level,
  output logic       eval_busy
);

  localparam int SW = 8 + LOG2_WIN;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  typedef enum logic [1:0] {S_ACCUM, S_DECIDE, S_PULSE, S_HOLD} state_e;
  typedef enum logic [1:0] {CMD_NONE, CMD_HOOG, CMD_LAAG, CMD_ALAAG} cmd_e;

  state_e                r_state;
  state_e                w_next;
  logic [SW-1:0]         r_sum;
  logic [LOG2_WIN-1:0]   r_cnt;
  logic [HW-1:0]         r_hold;
  logic [7:0]            r_prev;
  logic [7:0]            r_level;
  logic                  r_dir;
  logic                  r_first;
  logic                  r_f_hoog;
  logic                  r_f_laag;
  logic                  r_a_laag;

  logic [7:0]            w_avg;
  logic [8:0]            w_avg9;
  logic [8:0]            w_prev9;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_quiet;
  logic                  w_step;
  logic                  w_dir_next;
  cmd_e                  w_cmd;

  assign w_avg   = r_sum[LOG2_WIN +: 8];
  assign w_avg9  = {1'b0, w_avg};
  assign w_prev9 = {1'b0, r_prev};
  // Widened to 9 bits so adding the hysteresis to 255 cannot wrap.
  assign w_rise  = w_avg9 > (w_prev9 + 9'(HYST));
  assign w_fall  = w_prev9 > (w_avg9 + 9'(HYST));
  assign w_quiet = w_avg9 < 9'(QUIET);

  // Decision for the window just completed; only consumed in S_DECIDE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_cmd      = CMD_NONE;
    w_dir_next = r_dir;
    w_step     = 1'b0;
    if (!r_first) begin
      if (w_rise) begin
        w_dir_next = ~r_dir;
        w_step     = 1'b1;
      end else if (w_fall) begin
        w_step     = 1'b1;
      end else if (w_quiet && (fag_a > 4'(A_MIN))) begin
        w_cmd      = CMD_ALAAG;
      end
      if (w_step) begin
        if (!w_dir_next) begin
          if (fag_f < 4'(F_MAX)) w_cmd = CMD_HOOG;
        end else begin
          if (fag_f > 4'(F_MIN)) w_cmd = CMD_LAAG;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_ACCUM;
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_ACCUM:  if (sample_valid && (r_cnt == '1)) w_next = S_DECIDE;
      S_DECIDE: w_next = (w_cmd != CMD_NONE) ? S_PULSE : S_ACCUM;
      S_PULSE:  w_next = (HOLDOFF == 0) ? S_ACCUM : S_HOLD;
      S_HOLD:   if (r_hold <= HW'(1)) w_next = S_ACCUM;
      default:  w_next = S_ACCUM;
    endcase
  end

  always_comb begin
    eval_busy = (r_state != S_ACCUM);
    f_hoog    = r_f_hoog;
    f_laag    = r_f_laag;
    a_laag    = r_a_laag;
    level     = r_level;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum    <= '0;
      r_cnt    <= '0;
      r_hold   <= '0;
      r_prev   <= '0;
      r_level  <= '0;
      r_dir    <= 1'b0;
      r_first  <= 1'b1;
      r_f_hoog <= 1'b0;
      r_f_laag <= 1'b0;
      r_a_laag <= 1'b0;
    end else begin
      // Pulses are registered out of DECIDE, so they are high only in PULSE.
      r_f_hoog <= (r_state == S_DECIDE) && (w_cmd == CMD_HOOG);
      r_f_laag <= (r_state == S_DECIDE) && (w_cmd == CMD_LAAG);
      r_a_laag <= (r_state == S_DECIDE) && (w_cmd == CMD_ALAAG);
      unique case (r_state)
        S_ACCUM: begin
          if (sample_valid) begin
            r_sum <= r_sum + SW'(sample);
            r_cnt <= r_cnt + LOG2_WIN'(1);
          end
        end
        S_DECIDE: begin
          r_level <= w_avg;
          r_prev  <= w_avg;
          r_sum   <= '0;
          r_cnt   <= '0;
          r_first <= 1'b0;
          r_dir   <= w_dir_next;
        end
        S_PULSE:  r_hold <= HOLD_LOAD;
        S_HOLD:   r_hold <= r_hold - HW'(1);
        default:  r_hold <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cry_level_eval.sv
// Self-checking bench for cry_level_eval: a directed window table, a mid-window
// reset sequence and randomized windows checked against a per-window model.
module tb_cry_level_eval;

  localparam int HYST    = 8;
  localparam int QUIET   = 16;
  localparam int HOLDOFF = 1000;
  localparam int F_MAX   = 15;
  localparam int F_MIN   = 1;
  localparam int A_MIN   = 1;

  // Pulse codes as {f_hoog, f_laag, a_laag}.
  localparam int C_NONE  = 0;
  localparam int C_ALAAG = 1;
  localparam int C_LAAG  = 2;
  localparam int C_HOOG  = 4;

  typedef struct {
    int val;
    int f;
    int a;
    int exp_level;
    int exp_cmd;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       sample_valid;
  logic [7:0] sample;
  logic [3:0] fag_f;
  logic [3:0] fag_a;
  logic       f_hoog;
  logic       f_laag;
  logic       a_laag;
  logic [7:0] level;
  logic       eval_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int win_vals [16];

  // Window-level reference state.
  int m_prev;
  int m_dir;
  bit m_first;

  cry_level_eval dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .fag_f        (fag_f),
    .fag_a        (fag_a),
    .f_hoog       (f_hoog),
    .f_laag       (f_laag),
    .a_laag       (a_laag),
    .level        (level),
    .eval_busy    (eval_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pulses();
    return {29'd0, f_hoog, f_laag, a_laag};
  endfunction

  task automatic model_reset();
    m_prev  = 0;
    m_dir   = 0;
    m_first = 1'b1;
  endtask

  // Decision from the averaging rules: returns the expected pulse code.
  task automatic model_window(input int avg, input int f, input int a, output int cmd);
    bit step;
    cmd  = C_NONE;
    step = 1'b0;
    if (!m_first) begin
      if (avg > m_prev + HYST) begin
        m_dir = 1 - m_dir;
        step  = 1'b1;
      end else if (m_prev > avg + HYST) begin
        step  = 1'b1;
      end else if (avg < QUIET && a > A_MIN) begin
        cmd   = C_ALAAG;
      end
      if (step) begin
        if (m_dir == 0) cmd = (f < F_MAX) ? C_HOOG : C_NONE;
        else            cmd = (f > F_MIN) ? C_LAAG : C_NONE;
      end
    end
    m_prev  = avg;
    m_first = 1'b0;
  endtask

  // Feeds win_vals as one window and checks DECIDE, the pulse and the hold length.
  task automatic run_window(input int f, input int a, input int exp_level, input int exp_cmd,
                            input bit gaps, input string tag);
    int hold_n;
    int extra;
    fag_f = 4'(f);
    fag_a = 4'(a);
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        sample_valid = 1'b0;
        @(negedge clk);
      end
      sample_valid = 1'b1;
      sample       = 8'(win_vals[i]);
      @(negedge clk);
    end
    // DECIDE cycle: anything offered now must be discarded.
    sample_valid = 1'b1;
    sample       = 8'($urandom_range(0, 255));
    check({tag, " busy_decide"}, int'(eval_busy), 1);
    check({tag, " no_pulse_decide"}, pulses(), C_NONE);
    @(negedge clk);
    check({tag, " pulse"}, pulses(), exp_cmd);
    check({tag, " level"}, int'(level), exp_level);
    if (exp_cmd != C_NONE) begin
      check({tag, " busy_pulse"}, int'(eval_busy), 1);
      hold_n = 0;
      extra  = 0;
      for (int c = 0; c < 3000; c++) begin
        sample = 8'($urandom_range(0, 255));
        @(negedge clk);
        if (!eval_busy) break;
        hold_n++;
        if (pulses() != C_NONE) extra++;
      end
      check({tag, " hold_len"}, hold_n, HOLDOFF);
      check({tag, " hold_quiet"}, extra, 0);
    end else begin
      check({tag, " accum_again"}, int'(eval_busy), 0);
    end
    sample_valid = 1'b0;
  endtask

  vec_t tbl [11];

  initial begin
    int cmd;
    int base;
    int s;
    int f;
    int a;

    // val, f, a, level, pulse
    tbl[0]  = '{50,  5,  3, 50,  C_NONE};   // first window after reset
    tbl[1]  = '{50,  5,  3, 50,  C_NONE};   // stable, not quiet
    tbl[2]  = '{70,  5,  3, 70,  C_LAAG};   // rising: dir 0->1, step down
    tbl[3]  = '{40,  1,  3, 40,  C_NONE};   // falling, blocked by F_MIN
    tbl[4]  = '{12,  1,  3, 12,  C_NONE};   // falling again, still blocked
    tbl[5]  = '{10,  1,  3, 10,  C_ALAAG};  // stable and quiet
    tbl[6]  = '{10,  1,  1, 10,  C_NONE};   // quiet but A at minimum
    tbl[7]  = '{255, 15, 1, 255, C_NONE};   // full-scale window, rising blocked by F_MAX
    tbl[8]  = '{200, 14, 1, 200, C_HOOG};   // falling with dir 0
    tbl[9]  = '{208, 14, 1, 208, C_NONE};   // exactly HYST above: stable
    tbl[10] = '{217, 14, 1, 217, C_LAAG};   // HYST+1 above: rising, dir 0->1

    reset        = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    fag_f        = 4'd5;
    fag_a        = 4'd3;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset pulses", pulses(), C_NONE);
    check("reset level", int'(level), 0);
    check("reset busy", int'(eval_busy), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 16; k++) win_vals[k] = tbl[i].val;
      model_window(tbl[i].val, tbl[i].f, tbl[i].a, cmd);
      run_window(tbl[i].f, tbl[i].a, tbl[i].exp_level, tbl[i].exp_cmd, 1'b0,
                 $sformatf("vec%0d", i));
    end

    // Reset part-way through a window.
    fag_f = 4'd5;
    fag_a = 4'd5;
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample       = 8'd100;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midreset level", int'(level), 0);
    check("midreset pulses", pulses(), C_NONE);
    check("midreset busy", int'(eval_busy), 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 16; k++) win_vals[k] = 30;
    model_window(30, 5, 5, cmd);
    run_window(5, 5, 30, C_NONE, 1'b0, "after_reset");

    // Randomized windows against the model.
    for (int w = 0; w < 30; w++) begin
      base = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 255));
      s = 0;
      for (int k = 0; k < 16; k++) begin
        win_vals[k] = base + int'($urandom_range(0, 12)) - 6;
        if (win_vals[k] < 0)   win_vals[k] = 0;
        if (win_vals[k] > 255) win_vals[k] = 255;
        s += win_vals[k];
      end
      f = int'($urandom_range(0, 15));
      a = int'($urandom_range(0, 15));
      model_window(s / 16, f, a, cmd);
      run_window(f, a, s / 16, cmd, 1'b1, $sformatf("rnd%0d", w));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
